// File: rtl/efb_spi_sequencer_pkg.sv
// Shared definitions for the EFB SPI sequencer: EFB register map, SPISR
// status bit positions, FSM state encodings and the single-access payload.
package efb_spi_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADR_W  = 8;
  localparam int unsigned TO_W   = 16;

  // EFB hard SPI register addresses
  localparam logic [ADR_W-1:0] ADR_SPICR1  = 8'h55;
  localparam logic [ADR_W-1:0] ADR_SPICR2  = 8'h56;
  localparam logic [ADR_W-1:0] ADR_SPIBR   = 8'h57;
  localparam logic [ADR_W-1:0] ADR_SPICSR  = 8'h58;
  localparam logic [ADR_W-1:0] ADR_SPITXDR = 8'h59;
  localparam logic [ADR_W-1:0] ADR_SPISR   = 8'h5A;
  localparam logic [ADR_W-1:0] ADR_SPIRXDR = 8'h5B;

  // SPISR status bits
  localparam int unsigned SR_TRDY_BIT = 4;
  localparam int unsigned SR_RRDY_BIT = 3;

  typedef enum logic [3:0] {
    S_INIT_CR1,
    S_INIT_CR2,
    S_INIT_BR,
    S_IDLE,
    S_CS_ASSERT,
    S_POLL_TRDY,
    S_WR_TX,
    S_POLL_RRDY,
    S_RD_RX,
    S_CS_RELEASE,
    S_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ACTIVE,
    WB_ACK_LOW
  } wb_state_t;

  // One Wishbone register access request
  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] wdat;
  } wb_req_t;

endpackage

// File: rtl/efb_spi_sequencer_if.sv
// Bundles the byte request/response stream and the EFB Wishbone port.
// master: the sequencer (accepts bytes, drives the Wishbone bus).
// slave : the environment (byte requester plus EFB register file).
interface efb_spi_sequencer_if;
  import efb_spi_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              req_last;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADR_W-1:0]  wb_adr;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack;

  modport master (
    input  req_valid, req_data, req_last, wb_dat_o, wb_ack,
    output req_ready, rsp_valid, rsp_data,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i
  );

  modport slave (
    output req_valid, req_data, req_last, wb_dat_o, wb_ack,
    input  req_ready, rsp_valid, rsp_data,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i
  );
endinterface

// File: rtl/efb_spi_sequencer_wb_single_master.sv
// Performs one Wishbone register access per start request.
// Ports: clock/reset; start,we,adr,wdat request; done (ack cycle),
// rdat (read data, valid with done), timeout (ack never came);
// bus_* drive/observe the Wishbone master signals.
// A start issued while a stretched ack is still high is parked and
// launched once ack is seen low.
module wb_single_master
  import efb_spi_sequencer_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              we,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] wdat,
  output logic              done,
  output logic [DATA_W-1:0] rdat,
  output logic              timeout,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADR_W-1:0]  bus_adr,
  output logic [DATA_W-1:0] bus_dat_w,
  input  logic [DATA_W-1:0] bus_dat_r,
  input  logic              bus_ack
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  wb_state_t         state_q, state_d;
  wb_req_t           pend_q, cur;
  logic              pend_vld_q;
  logic              act_q, we_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [TO_W-1:0]   cnt_q;
  logic              want, launch, park;

  assign rdat      = bus_dat_r;
  assign bus_cyc   = act_q;
  assign bus_stb   = act_q;
  assign bus_we    = we_q;
  assign bus_adr   = adr_q;
  assign bus_dat_w = dat_q;

  // Access sequencing: launch, wait for ack or timeout, wait for ack low
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    park    = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    want    = start | pend_vld_q;
    cur     = pend_q;
    if (start) begin
      cur.we   = we;
      cur.adr  = adr;
      cur.wdat = wdat;
    end
    case (state_q)
      WB_IDLE: begin
        if (want) begin
          launch  = 1'b1;
          state_d = WB_ACTIVE;
        end
      end
      WB_ACTIVE: begin
        if (bus_ack) begin
          done    = 1'b1;
          state_d = WB_ACK_LOW;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = WB_IDLE;
        end
      end
      WB_ACK_LOW: begin
        if (!bus_ack) begin
          if (want) begin
            launch  = 1'b1;
            state_d = WB_ACTIVE;
          end else begin
            state_d = WB_IDLE;
          end
        end else if (start) begin
          park = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= WB_IDLE;
    else       state_q <= state_d;
  end

  // Bus drivers, timeout counter and parked request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (launch) begin
        act_q      <= 1'b1;
        we_q       <= cur.we;
        adr_q      <= cur.adr;
        dat_q      <= cur.wdat;
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
      end else if (done || timeout) begin
        act_q <= 1'b0;
        we_q  <= 1'b0;
        adr_q <= '0;
        dat_q <= '0;
      end else if (state_q == WB_ACTIVE) begin
        cnt_q <= cnt_q + TO_W'(1);
      end
      if (park) begin
        pend_q     <= cur;
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/efb_spi_sequencer.sv
// Byte-stream SPI sequencer driving the EFB hard SPI master over Wishbone.
// Ports: clock, reset (async, active-high); bus (req/rsp byte stream and
// Wishbone master port); busy (not idle); error (sticky ack timeout).
module efb_spi_sequencer
  import efb_spi_sequencer_pkg::*;
#(
  parameter logic [7:0]  CR1_VAL     = 8'h80,
  parameter logic [7:0]  CR2_VAL     = 8'hC0,
  parameter logic [7:0]  BR_VAL      = 8'h03,
  parameter logic [7:0]  CS_MASK     = 8'h01,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  efb_spi_sequencer_if.master   bus,
  output logic                  busy,
  output logic                  error
);

  seq_state_t        state_q, state_d;
  logic              issued_q, issued_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, busy_q, error_q;

  logic              is_acc, acc_start, acc_we;
  logic [ADR_W-1:0]  acc_adr;
  logic [DATA_W-1:0] acc_wdat;
  logic              acc_done, acc_timeout;
  logic [DATA_W-1:0] acc_rdat;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign error         = error_q;

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wb (
    .clock     (clock),
    .reset     (reset),
    .start     (acc_start),
    .we        (acc_we),
    .adr       (acc_adr),
    .wdat      (acc_wdat),
    .done      (acc_done),
    .rdat      (acc_rdat),
    .timeout   (acc_timeout),
    .bus_cyc   (bus.wb_cyc),
    .bus_stb   (bus.wb_stb),
    .bus_we    (bus.wb_we),
    .bus_adr   (bus.wb_adr),
    .bus_dat_w (bus.wb_dat_i),
    .bus_dat_r (bus.wb_dat_o),
    .bus_ack   (bus.wb_ack)
  );

  // Sequencer: per-state access, then transition on that access's ack
  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    frame_d     = frame_q;
    last_d      = last_q;
    tx_d        = tx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    is_acc      = 1'b1;
    acc_we      = 1'b1;
    acc_adr     = '0;
    acc_wdat    = '0;

    case (state_q)
      S_INIT_CR1:   begin acc_adr = ADR_SPICR1;  acc_wdat = CR1_VAL; end
      S_INIT_CR2:   begin acc_adr = ADR_SPICR2;  acc_wdat = CR2_VAL; end
      S_INIT_BR:    begin acc_adr = ADR_SPIBR;   acc_wdat = BR_VAL;  end
      S_CS_ASSERT:  begin acc_adr = ADR_SPICSR;  acc_wdat = CS_MASK; end
      S_POLL_TRDY:  begin acc_we  = 1'b0; acc_adr = ADR_SPISR;       end
      S_WR_TX:      begin acc_adr = ADR_SPITXDR; acc_wdat = tx_q;    end
      S_POLL_RRDY:  begin acc_we  = 1'b0; acc_adr = ADR_SPISR;       end
      S_RD_RX:      begin acc_we  = 1'b0; acc_adr = ADR_SPIRXDR;     end
      S_CS_RELEASE: begin acc_adr = ADR_SPICSR;  acc_wdat = '0;      end
      default:      is_acc = 1'b0;
    endcase

    // Each access state issues exactly one request; polls re-enter to re-issue
    acc_start = is_acc && !issued_q;
    if (acc_start) issued_d = 1'b1;

    if (is_acc && acc_timeout) begin
      issued_d = 1'b0;
      state_d  = S_ERROR;
    end else if (is_acc && acc_done) begin
      issued_d = 1'b0;
      case (state_q)
        S_INIT_CR1:  state_d = S_INIT_CR2;
        S_INIT_CR2:  state_d = S_INIT_BR;
        S_INIT_BR:   state_d = S_IDLE;
        S_CS_ASSERT: begin
          frame_d = 1'b1;
          state_d = S_POLL_TRDY;
        end
        S_POLL_TRDY: if (acc_rdat[SR_TRDY_BIT]) state_d = S_WR_TX;
        S_WR_TX:     state_d = S_POLL_RRDY;
        S_POLL_RRDY: if (acc_rdat[SR_RRDY_BIT]) state_d = S_RD_RX;
        S_RD_RX: begin
          rsp_data_d  = acc_rdat;
          rsp_valid_d = 1'b1;
          state_d     = last_q ? S_CS_RELEASE : S_IDLE;
        end
        S_CS_RELEASE: begin
          frame_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end

    if (state_q == S_IDLE && bus.req_valid) begin
      tx_d    = bus.req_data;
      last_d  = bus.req_last;
      state_d = frame_q ? S_POLL_TRDY : S_CS_ASSERT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT_CR1;
      issued_q    <= 1'b0;
      frame_q     <= 1'b0;
      last_q      <= 1'b0;
      tx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      frame_q     <= frame_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      error_q     <= error_q | (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_efb_spi_sequencer.sv
// Bench for efb_spi_sequencer: behavioural EFB register model with
// configurable ack latency/stretch and SPISR readiness, randomized frames
// compared against an expected access list built from the register rules.
module tb_efb_spi_sequencer;
  import efb_spi_sequencer_pkg::*;

  localparam int unsigned TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, error;

  efb_spi_sequencer_if bus();

  efb_spi_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .error (error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- EFB model ----------------
  int lat_cfg = 1, hold_cfg = 1, trdy_wait = 0, rrdy_wait = 0;
  bit never_ack = 1'b0;
  int wait_cnt, hold_left, tcnt, rcnt;
  bit phase;
  logic [7:0]  rx_q[$];
  logic [16:0] log_q[$];
  logic [7:0]  rsp_q[$];

  function automatic logic [7:0] efb_access(logic we, logic [7:0] adr, logic [7:0] wd);
    logic [7:0] rd = 8'h00;
    log_q.push_back({we, adr, we ? wd : 8'h00});
    if (we) begin
      if (adr == 8'h59) begin phase = 1'b1; rcnt = 0; end
    end else if (adr == 8'h5A) begin
      if (!phase) begin
        if (tcnt >= trdy_wait) rd = 8'h10; else tcnt++;
      end else begin
        if (rcnt >= rrdy_wait) rd = 8'h08; else rcnt++;
      end
    end else if (adr == 8'h5B) begin
      rd = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
      phase = 1'b0;
      tcnt = 0;
    end
    return rd;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.wb_ack   <= 1'b0;
      bus.wb_dat_o <= 8'h00;
      wait_cnt = 0; hold_left = 0; tcnt = 0; rcnt = 0; phase = 1'b0;
    end else if (bus.wb_ack) begin
      if (hold_left > 1) hold_left = hold_left - 1;
      else bus.wb_ack <= 1'b0;
    end else if (bus.wb_stb && !never_ack) begin
      if (wait_cnt + 1 >= lat_cfg) begin
        wait_cnt = 0;
        hold_left = hold_cfg;
        bus.wb_ack   <= 1'b1;
        bus.wb_dat_o <= efb_access(bus.wb_we, bus.wb_adr, bus.wb_dat_i);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- monitors ----------------
  int stb_run = 0, last_run = 0, viol = 0;
  logic ack_prev = 1'b0, stb_prev = 1'b0;
  logic [16:0] bits_prev = '0;

  always @(negedge clock) if (bus.rsp_valid) rsp_q.push_back(bus.rsp_data);

  always @(posedge clock) begin
    if (bus.wb_stb) stb_run++;
    else begin
      if (stb_run > 0) last_run = stb_run;
      stb_run = 0;
    end
    // no strobe during a stretched ack; request stable while waiting
    if (bus.wb_stb && bus.wb_ack && ack_prev) viol++;
    if (bus.wb_stb && stb_prev && !ack_prev &&
        {bus.wb_we, bus.wb_adr, bus.wb_dat_i} != bits_prev) viol++;
    ack_prev  = bus.wb_ack;
    stb_prev  = bus.wb_stb;
    bits_prev = {bus.wb_we, bus.wb_adr, bus.wb_dat_i};
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (!bus.req_ready && n < bound) begin @(negedge clock); n++; end
    check(tag, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    bus.req_last  = last;
    while (!bus.req_ready && n < 2000) begin @(negedge clock); n++; end
    if (!bus.req_ready) check("req_handshake", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_init(input string tag);
    check({tag, "_n"}, 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      check({tag, "_cr1"}, 32'(log_q[0]), 32'({1'b1, 8'h55, 8'h80}));
      check({tag, "_cr2"}, 32'(log_q[1]), 32'({1'b1, 8'h56, 8'hC0}));
      check({tag, "_br"},  32'(log_q[2]), 32'({1'b1, 8'h57, 8'h03}));
    end
  endtask

  // Send a whole frame from a closed state and compare the bus accesses
  task automatic run_frame(input string tag, input logic [7:0] tx[$], input logic [7:0] rx[$]);
    logic [16:0] exp_q[$];
    int m;
    log_q.delete();
    rsp_q.delete();
    exp_q.push_back({1'b1, 8'h58, 8'h01});
    foreach (tx[i]) begin
      rx_q.push_back(rx[i]);
      for (int k = 0; k <= trdy_wait; k++) exp_q.push_back({1'b0, 8'h5A, 8'h00});
      exp_q.push_back({1'b1, 8'h59, tx[i]});
      for (int k = 0; k <= rrdy_wait; k++) exp_q.push_back({1'b0, 8'h5A, 8'h00});
      exp_q.push_back({1'b0, 8'h5B, 8'h00});
    end
    exp_q.push_back({1'b1, 8'h58, 8'h00});
    foreach (tx[i]) send_byte(tx[i], i == tx.size() - 1);
    wait_ready({tag, "_done"}, 2000);
    @(negedge clock);
    check({tag, "_nacc"}, 32'(log_q.size()), 32'(exp_q.size()));
    m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_acc%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    check({tag, "_nrsp"}, 32'(rsp_q.size()), 32'(rx.size()));
    m = (rsp_q.size() < rx.size()) ? rsp_q.size() : rx.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_rsp%0d", tag, i), 32'(rsp_q[i]), 32'(rx[i]));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  function automatic bit tx_seen();
    foreach (log_q[i]) if (log_q[i][16:8] == {1'b1, 8'h59}) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] txq[$], rxq[$];
    int n;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.req_last  = 1'b0;

    // reset values
    repeat (2) @(negedge clock);
    check("rst_cyc",       32'(bus.wb_cyc),    32'd0);
    check("rst_stb",       32'(bus.wb_stb),    32'd0);
    check("rst_we",        32'(bus.wb_we),     32'd0);
    check("rst_adr",       32'(bus.wb_adr),    32'd0);
    check("rst_dat",       32'(bus.wb_dat_i),  32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("rst_busy",      32'(busy),          32'd1);
    check("rst_error",     32'(error),         32'd0);

    // init sequence
    log_q.delete();
    reset = 1'b0;
    wait_ready("init_ready", 200);
    check_init("init");
    check("idle_busy", 32'(busy), 32'd0);

    // single byte: TRDY after 2 polls, RX 0x3C
    trdy_wait = 1; rrdy_wait = 0;
    txq.delete(); rxq.delete();
    txq.push_back(8'hA5); rxq.push_back(8'h3C);
    run_frame("single", txq, rxq);

    // three-byte frame with ack stretched to 3 cycles
    hold_cfg = 3; trdy_wait = 0; rrdy_wait = 1;
    txq.delete(); rxq.delete();
    for (int i = 0; i < 3; i++) begin
      txq.push_back(8'($urandom)); rxq.push_back(8'($urandom));
    end
    run_frame("three", txq, rxq);
    check("stretch_viol", 32'(viol), 32'd0);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      lat_cfg   = $urandom_range(1, 3);
      hold_cfg  = $urandom_range(1, 3);
      trdy_wait = $urandom_range(0, 2);
      rrdy_wait = $urandom_range(0, 2);
      txq.delete(); rxq.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        txq.push_back(8'($urandom)); rxq.push_back(8'($urandom));
      end
      run_frame($sformatf("rand%0d", f), txq, rxq);
    end
    check("rand_viol",  32'(viol),  32'd0);
    check("rand_error", 32'(error), 32'd0);

    // reset in the middle of POLL_RRDY
    lat_cfg = 1; hold_cfg = 1; trdy_wait = 0; rrdy_wait = 40;
    log_q.delete(); rx_q.delete();
    rx_q.push_back(8'h77);
    send_byte(8'h5C, 1'b1);
    n = 0;
    while (!tx_seen() && n < 300) begin @(negedge clock); n++; end
    check("mid_tx_seen", 32'(tx_seen()), 32'd1);
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_cyc",       32'(bus.wb_cyc),    32'd0);
    check("mid_stb",       32'(bus.wb_stb),    32'd0);
    check("mid_adr",       32'(bus.wb_adr),    32'd0);
    check("mid_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rsp_data",  32'(bus.rsp_data),  32'd0);
    check("mid_busy",      32'(busy),          32'd1);
    repeat (2) @(negedge clock);
    rx_q.delete(); log_q.delete();
    rrdy_wait = 0;
    reset = 1'b0;
    wait_ready("reinit_ready", 200);
    check_init("reinit");
    txq.delete(); rxq.delete();
    txq.push_back(8'hC3); rxq.push_back(8'h5A);
    run_frame("after_rst", txq, rxq);

    // ack never arrives
    never_ack = 1'b1;
    log_q.delete();
    send_byte(8'h11, 1'b1);
    n = 0;
    while (!error && n < 200) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    check("to_error",     32'(error),         32'd1);
    check("to_stb_run",   32'(last_run),      32'(TO));
    check("to_stb",       32'(bus.wb_stb),    32'd0);
    check("to_req_ready", 32'(bus.req_ready), 32'd0);
    check("to_busy",      32'(busy),          32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h22;
    repeat (30) @(negedge clock);
    check("to_sticky",    32'(error),         32'd1);
    check("to_ready_hold",32'(bus.req_ready), 32'd0);
    check("to_no_bus",    32'(stb_run),       32'd0);
    check("to_no_access", 32'(log_q.size()),  32'd0);
    bus.req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/efb_spi_sequencer.md
# efb_spi_sequencer

Byte-level SPI transaction sequencer that owns the Wishbone port of the EFB hard SPI master and turns a simple valid/ready byte stream into the required register accesses. It covers one-time configuration, status polling, TX/RX data movement, chip-select framing and bus-hang detection. It sits between the CPLD's command logic and the EFB and replaces hard-coded single-access Wishbone sequences.

## Interface
- `CR1_VAL`, default 8'h80: SPICR1 value (SPE=1).
- `CR2_VAL`, default 8'hC0: SPICR2 value (MSTR=1, MCSH=1, mode 0, MSB first).
- `BR_VAL`, default 8'h03: SPIBR divider.
- `CS_MASK`, default 8'h01: SPICSR value asserting the target chip select.
- `ACK_TIMEOUT`, default 255: max cycles `wb_stb` waits for `wb_ack` (range 1..65535).
- `clock` in 1: system clock; reset `reset`, asynchronous, active-high; clock `clock`.
- `reset` in 1: asynchronous active-high reset.
- `req_valid` in 1: byte request present.
- `req_ready` out 1: sequencer accepts `req_*` this cycle.
- `req_data` in 8: byte to shift out.
- `req_last` in 1: last byte of frame; CS released after it.
- `rsp_valid` out 1: one-cycle pulse, `rsp_data` valid.
- `rsp_data` out 8: byte shifted in.
- `busy` out 1: high in every state except IDLE.
- `error` out 1: sticky; set on ack timeout, cleared only by reset.
- `wb_cyc`, `wb_stb`, `wb_we` out 1: Wishbone master controls.
- `wb_adr` out 8: EFB register address.
- `wb_dat_i` out 8: write data to EFB.
- `wb_dat_o` in 8: read data from EFB.
- `wb_ack` in 1: EFB acknowledge.

## Operation
- Register map (fixed): SPICR1 0x55, SPICR2 0x56, SPIBR 0x57, SPICSR 0x58, SPITXDR 0x59, SPISR 0x5A, SPIRXDR 0x5B. SPISR.TRDY = bit 4, SPISR.RRDY = bit 3.
- States: INIT_CR1 → INIT_CR2 → INIT_BR → IDLE → [CS_ASSERT] → POLL_TRDY → WR_TX → POLL_RRDY → RD_RX → (IDLE | CS_RELEASE → IDLE). ERROR is terminal.
- INIT_*: write CR1_VAL, CR2_VAL and BR_VAL, one access each. These run only after reset.
- IDLE: `req_ready`=1. On `req_valid`, latch data and last. If no frame is open, go to CS_ASSERT, which writes SPICSR=CS_MASK and opens the frame. Otherwise go straight to POLL_TRDY.
- POLL_TRDY: read SPISR, repeat until bit 4 is 1. WR_TX: write the latched byte to SPITXDR.
- POLL_RRDY: read SPISR, repeat until bit 3 is 1. RD_RX: read SPIRXDR. On its ack, capture `wb_dat_o` into `rsp_data` and pulse `rsp_valid`.
- After RD_RX: if last is set, go to CS_RELEASE (write SPICSR=8'h00, close the frame), then IDLE. Otherwise go to IDLE with the frame still open.
- Any access exceeding ACK_TIMEOUT cycles without ack: drop cyc/stb, set `error`, enter ERROR. In ERROR, `req_ready`=0, `busy`=1 and there is no further bus activity.
- `req_valid` is ignored outside IDLE. Requesters must hold it until `req_ready`.

## Timing
- Reset values: all wb outputs 0, `wb_adr`/`wb_dat_i` 8'h00, `req_ready` 0, `rsp_valid` 0, `rsp_data` 8'h00, `busy` 1, `error` 0, state INIT_CR1, frame closed.
- Single access: cyc/stb/we/adr/dat are driven in the cycle after the access is started and held stable until `wb_ack` is sampled high. In the next cycle all five return to 0. The next access may not start until `wb_ack` is sampled low (handles a stretched ack).
- Read data is sampled in the cycle `wb_ack`=1.
- `req_ready` is registered: high exactly while in IDLE, and drops the cycle after the handshake.
- `rsp_valid` goes high for one cycle, in the cycle after the RD_RX ack.
- Timeout counter resets at each access start and counts stb-high cycles. A value of ACK_TIMEOUT with no ack triggers the timeout on that cycle.
- Reset mid-access: cyc/stb drop immediately (asynchronous), the frame closes and INIT restarts. CS is not explicitly released; INIT does not touch SPICSR.

## Structure
- The shared package holds the EFB register address constants, the SPISR bit indices and the state enum.
- Sub-module `wb_single_master` handles one access. Inputs: start, we, adr, wdat. Outputs: done, rdat, timeout. It implements the hold, drop and wait-for-ack-low rule plus the timeout counter.
- The top level holds the sequencing FSM, the frame flag and the response register.

## Test plan
- Reset release, EFB model acks in 1 cycle → writes 0x55←0x80, 0x56←0xC0, 0x57←0x03 in order, then `req_ready`=1.
- Single byte 0xA5 with last=1, model returns TRDY after 2 polls and RX byte 0x3C → accesses in order: 0x58←0x01, SPISR reads, 0x59←0xA5, SPISR reads, read 0x5B, 0x58←0x00. `rsp_data`=0x3C with a single `rsp_valid` pulse.
- Three-byte frame (last only on the 3rd byte) → exactly one CS assert before byte 1 and one release after byte 3, three `rsp_valid` pulses.
- Ack held high for 3 cycles → master deasserts after the first ack cycle and issues no new stb until ack is low. Exactly one register effect per access.
- Model never acks, ACK_TIMEOUT=16 → stb drops after 16 cycles, `error`=1 sticky, `req_ready` stays 0.
- Reset asserted mid POLL_RRDY → outputs return to reset values in the same cycle, and the INIT sequence reruns after release.
